btn_onehot_debounce: RTL

Upstream stage for the 4-to-2 enable encoder. It takes four raw, asynchronous push-button lines, synchronises and debounces them, and presents a clean one-hot code plus an enable to the encoder's `a`/`en` inputs. Simultaneous multi-button presses are rejected and flagged; they are never passed through as non-one-hot codes.

---
 rtl/btn_pkg.sv | 18 +
 rtl/sync_2ff.sv | 27 ++
 rtl/btn_onehot_debounce.sv | 139 +++++++++++++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encoding,
// button count and the one-hot test used when a press is accepted.
package btn_pkg;

  localparam int BTN_N = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    HELD    = 2'd2,
    RELEASE = 2'd3
  } state_e;

  function automatic logic is_onehot(input logic [BTN_N-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs; both stages clear
// on reset so a level held through reset is seen afresh afterwards.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/btn_onehot_debounce.sv
// Debounces four raw buttons into a one-hot code + enable for the encoder.
// Optional macro BTN_LATCH_EN: keep the last accepted code on release/roll-over.
module btn_onehot_debounce
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BTN_N-1:0] btn,
  output logic [BTN_N-1:0] onehot,
  output logic             en,
  output logic             valid,
  output logic             multi
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef BTN_LATCH_EN
  localparam logic CLEAR_ON_DROP = 1'b0;
`else
  localparam logic CLEAR_ON_DROP = 1'b1;
`endif

  logic [BTN_N-1:0] btn_s;

  state_e           state_q,  state_d;
  logic [BTN_N-1:0] cand_q,   cand_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [BTN_N-1:0] onehot_q, onehot_d;
  logic             en_q,     en_d;
  logic             valid_q,  valid_d;
  logic             multi_q,  multi_d;

  sync_2ff #(.W(BTN_N)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (btn),
    .q_o   (btn_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cand_q   <= '0;
      cnt_q    <= '0;
      onehot_q <= '0;
      en_q     <= 1'b0;
      valid_q  <= 1'b0;
      multi_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      onehot_q <= onehot_d;
      en_q     <= en_d;
      valid_q  <= valid_d;
      multi_q  <= multi_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    onehot_d = onehot_q;
    en_d     = en_q;
    valid_d  = 1'b0;
    multi_d  = multi_q;

    case (state_q)
      IDLE: begin
        if (btn_s != '0) begin
          cand_d  = btn_s;
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (btn_s == '0) begin
          state_d = IDLE;
        end else if (btn_s != cand_q) begin
          cand_d = btn_s;
          cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          // A multi-button chord is flagged but never forwarded to the encoder
          if (is_onehot(cand_q)) begin
            onehot_d = cand_q;
            en_d     = 1'b1;
            valid_d  = 1'b1;
          end else begin
            onehot_d = '0;
            en_d     = 1'b0;
            multi_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (btn_s != cand_q) begin
          cnt_d   = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (btn_s == cand_q) begin
          state_d = HELD;
        end else if (btn_s != '0) begin
          cand_d  = btn_s;
          cnt_d   = '0;
          state_d = SETTLE;
          multi_d = 1'b0;
          if (CLEAR_ON_DROP) begin
            onehot_d = '0;
            en_d     = 1'b0;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          multi_d = 1'b0;
          if (CLEAR_ON_DROP) begin
            onehot_d = '0;
            en_d     = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign onehot = onehot_q;
  assign en     = en_q;
  assign valid  = valid_q;
  assign multi  = multi_q;

endmodule
